// File: rtl/pc_unit.sv
// Program counter with jump, relative branch, call/return and an optional
// return-address stack, compiled in when PC_UNIT_RAS_EN is defined.
module pc_unit #(
  parameter int WIDTH     = 32,
  parameter int RESET_VEC = 8,
  parameter int STEP      = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             jmp,
  input  logic             br,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] off,
  output logic [WIDTH-1:0] dout,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] seq_pc;

  assign seq_pc = pc_reg + STEP_W;
  assign dout   = pc_reg;

`ifdef PC_UNIT_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(RAS_DEPTH);

  // Circular buffer: a push past full simply overwrites the oldest slot.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top_reg;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      cnt_reg;
  logic             err_reg;
  logic             empty_w;
  logic             full_w;
  logic             push;
  logic             pop;
  logic             err_set;

  assign empty_w = (cnt_reg == '0);
  assign full_w  = (cnt_reg == FULL_CNT);
  assign wr_ptr  = top_reg + 1'b1;

  always_comb begin
    pc_next = seq_pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (ret) begin
      if (empty_w) begin
        err_set = 1'b1;
      end else begin
        pc_next = ras_mem[top_reg];
        pop     = 1'b1;
      end
    end else if (call) begin
      pc_next = din;
      push    = 1'b1;
      err_set = full_w;
    end else if (jmp) begin
      pc_next = din;
    end else if (br) begin
      pc_next = pc_reg + off;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_reg <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else if (we) begin
      if (push) begin
        top_reg <= wr_ptr;
        if (!full_w) cnt_reg <= cnt_reg + 1'b1;
      end else if (pop) begin
        top_reg <= top_reg - 1'b1;
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (err_set) err_reg <= 1'b1;
    end
  end

  // Entry storage is never cleared; it is unreachable while the count is zero.
  always_ff @(posedge clk) begin
    if (rst && we && push) ras_mem[wr_ptr] <= seq_pc;
  end

  assign ras_empty = empty_w;
  assign ras_full  = full_w;
  assign ras_err   = err_reg;
`else
  // Without the stack, call degrades to jump and ret to a sequential advance.
  always_comb begin
    pc_next = seq_pc;
    if (ret) begin
      pc_next = seq_pc;
    end else if (call || jmp) begin
      pc_next = din;
    end else if (br) begin
      pc_next = pc_reg + off;
    end
  end

  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (we) begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning PC/data width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 8, meaning PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4, meaning sequential increment.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of two, >=2).
REQ-005 SHALL have port clk  input  1  clock, rising-edge active.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port we  input  1  update enable; PC and stack change only when high.
REQ-008 SHALL have port jmp  input  1  absolute jump to din.
REQ-009 SHALL have port br  input  1  relative branch: PC + off.
REQ-010 SHALL have port call  input  1  jump to din and push PC+STEP.
REQ-011 SHALL have port ret  input  1  pop stack top into PC.
REQ-012 SHALL have port din  input  WIDTH  jump/call target.
REQ-013 SHALL have port off  input  WIDTH  two's-complement branch offset.
REQ-014 SHALL have port dout  output  WIDTH  current PC.
REQ-015 SHALL have port ras_empty  output  1  stack holds 0 entries.
REQ-016 SHALL have port ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-017 SHALL have port ras_err  output  1  sticky overflow/underflow flag.

Function
REQ-018 dout SHALL be driven directly from the PC register (no combinational path from inputs).
REQ-019 With we low, PC, stack, count and ras_err SHALL hold regardless of other inputs.
REQ-020 With we high, exactly one action per cycle, priority ret > call > jmp > br > sequential (PC+STEP).
REQ-021 All PC arithmetic SHALL be modulo 2^WIDTH; wrap from 2^WIDTH-STEP to 0 is silent.
REQ-022 br SHALL load PC+off with off sign-interpreted; e.g. PC 0x20, off 0xFFFFFFF8 -> 0x18.
REQ-023 call SHALL load din into PC and push PC+STEP in the same cycle; count +1.
REQ-024 call when full SHALL overwrite the oldest entry (circular), count stays RAS_DEPTH, ras_err set.
REQ-025 ret when non-empty SHALL load stack top into PC; count -1; lower entries preserved.
REQ-026 ret when empty SHALL perform a sequential advance instead, leave count 0, set ras_err.
REQ-027 Simultaneous call and ret SHALL execute only ret (call ignored, no push).
REQ-028 ras_err once set SHALL remain set until reset.
REQ-029 ras_empty/ras_full SHALL be registered-state decodes of the entry count, valid the cycle after the update.

Reset
REQ-030 rst low SHALL immediately, independent of clk, force PC=RESET_VEC, count=0, ras_err=0.
REQ-031 During reset outputs SHALL read dout=RESET_VEC, ras_empty=1, ras_full=0, ras_err=0.
REQ-032 Stack entry contents need not be cleared; they are unreachable while count=0.
REQ-033 Reset asserted mid-call/ret SHALL discard that operation entirely.
REQ-034 First update after rst deasserts SHALL occur on the first rising clk edge with rst high.

Configuration
REQ-035 Macro PC_UNIT_RAS_EN defined SHALL compile in the return-address stack as specified.
REQ-036 Without PC_UNIT_RAS_EN, call SHALL behave as jmp (no push), ret SHALL behave as sequential advance, ras_empty=1, ras_full=0, ras_err=0 constantly, no stack storage synthesised.

Verification
REQ-037 Reset then 3 cycles we=1 no controls -> dout 8, 0xC, 0x10, 0x14.
REQ-038 PC 0x14, jmp=1 din=0x100, then br=1 off=0xFFFFFFF0 -> dout 0x100 then 0xF0.
REQ-039 PC 0x100: call din=0x200, call din=0x300, ret, ret -> dout 0x200, 0x300, 0x204, 0x104; ras_empty=1 after; ras_err=0.
REQ-040 5 calls with RAS_DEPTH=4 then 5 rets -> 4 rets return newest-first, fifth ret advances by STEP, ras_full seen after 4th call, ras_err=1.
REQ-041 we=0 with jmp=1 din=0x500 for 2 cycles -> dout unchanged; ret and call together with one entry -> pops only, count 0.
REQ-042 Assert rst between edges after 2 calls -> dout=8 and ras_empty=1 immediately, without a clock edge; PC 0xFFFFFFFC sequential -> 0x0.
